// File: rtl/cache_victim_select.sv
// Victim-way selector: returns the lowest invalid way of a set, or an LFSR-chosen way
// when the set is full. It keeps a per-set valid bitmap and drives the LFSR advance strobe.
module cache_victim_select #(
   parameter int WAYS  = 4,
   parameter int SETS  = 64,
   parameter int WAY_W = $clog2(WAYS),
   parameter int SET_W = $clog2(SETS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       lfsr_val,
   output logic             lfsr_update,
   input  logic             req_valid,
   input  logic [SET_W-1:0] req_set,
   output logic             req_ready,
   output logic             resp_valid,
   output logic [WAY_W-1:0] resp_way,
   input  logic             resp_ready,
   input  logic             fill_done,
   input  logic             inv_valid,
   input  logic [SET_W-1:0] inv_set,
   input  logic [WAY_W-1:0] inv_way,
   input  logic             inv_all
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PICK,
      S_RESP,
      S_FILL
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [SET_W-1:0] r_set;
   logic [WAY_W-1:0] r_way;
   logic [WAYS-1:0]  r_valid [SETS];

   logic [WAYS-1:0]  w_row;
   logic [WAY_W-1:0] w_free_way;
   logic             w_has_free;
   logic             w_fill;
   logic             w_unused_lfsr;

   // Only the low WAY_W bits of the LFSR choose a way.
   assign w_unused_lfsr = ^lfsr_val[7:WAY_W];

   assign w_row  = r_valid[r_set];
   assign w_fill = (r_state == S_FILL) && fill_done;

   // Scanned from the top so the lowest-indexed invalid way wins.
   always_comb begin
      w_free_way = '0;
      w_has_free = 1'b0;
      for (int unsigned i = WAYS; i > 0; i--) begin
         if (!w_row[i-1]) begin
            w_free_way = WAY_W'(i - 1);
            w_has_free = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid)  w_next = S_PICK;
         S_PICK:                  w_next = S_RESP;
         S_RESP:  if (resp_ready) w_next = S_FILL;
         S_FILL:  if (fill_done)  w_next = S_IDLE;
         default:                 w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready   = (r_state == S_IDLE);
      resp_valid  = (r_state == S_RESP);
      lfsr_update = (r_state == S_PICK) && !w_has_free;
   end

   assign resp_way = r_way;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_set <= '0;
         r_way <= '0;
      end else begin
         if (r_state == S_IDLE && req_valid) begin
            r_set <= req_set;
         end
         if (r_state == S_PICK) begin
            r_way <= w_has_free ? w_free_way : lfsr_val[WAY_W-1:0];
         end
      end
   end

   // Later non-blocking write wins: the fill set overrides a same-bit invalidate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
         end
      end else if (inv_all) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
         end
      end else begin
         if (inv_valid) begin
            r_valid[inv_set][inv_way] <= 1'b0;
         end
         if (w_fill) begin
            r_valid[r_set][r_way] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cache_victim_select.sv
// Bench for cache_victim_select: directed vector table, reset/abort sequence, and
// randomized traffic checked against a bitmap model of the victim-selection rules.
module tb_cache_victim_select;

   localparam int WAYS  = 4;
   localparam int SETS  = 64;
   localparam int WAY_W = 2;
   localparam int SET_W = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       lfsr_val = '0;
   logic             lfsr_update;
   logic             req_valid = 1'b0;
   logic [SET_W-1:0] req_set = '0;
   logic             req_ready;
   logic             resp_valid;
   logic [WAY_W-1:0] resp_way;
   logic             resp_ready = 1'b0;
   logic             fill_done = 1'b0;
   logic             inv_valid = 1'b0;
   logic [SET_W-1:0] inv_set = '0;
   logic [WAY_W-1:0] inv_way = '0;
   logic             inv_all = 1'b0;

   cache_victim_select #(.WAYS(WAYS), .SETS(SETS)) dut (
      .clk(clk), .rst(rst), .lfsr_val(lfsr_val), .lfsr_update(lfsr_update),
      .req_valid(req_valid), .req_set(req_set), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_way(resp_way), .resp_ready(resp_ready),
      .fill_done(fill_done), .inv_valid(inv_valid), .inv_set(inv_set),
      .inv_way(inv_way), .inv_all(inv_all)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit mv [SETS][WAYS];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
   endfunction

   function automatic void model_pick(input int s, input int l, output int w, output bit upd);
      w = -1;
      for (int i = 0; i < WAYS; i++)
         if (!mv[s][i] && w < 0) w = i;
      upd = (w < 0);
      if (w < 0) w = l % WAYS;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input int s, input int l, input int stall, input int exp_w,
                         input bit exp_u, input bit pinv, input int pis, input int piw,
                         input bit finv, input int fis, input int fiw, input bit fall);
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_set   = SET_W'(s);
      lfsr_val  = 8'(l);
      tick();
      req_valid = 1'b0;
      check("lfsr_update_pick", lfsr_update, exp_u);
      check("resp_valid_pick", resp_valid, 0);
      check("req_ready_pick", req_ready, 0);
      if (pinv) begin
         inv_valid = 1'b1;
         inv_set   = SET_W'(pis);
         inv_way   = WAY_W'(piw);
      end
      tick();
      inv_valid = 1'b0;
      if (pinv) mv[pis][piw] = 1'b0;
      lfsr_val = ~8'(l);
      check("resp_valid_latency", resp_valid, 1);
      check("resp_way", resp_way, exp_w);
      check("lfsr_update_resp", lfsr_update, 0);
      for (int i = 0; i < stall; i++) begin
         req_valid = 1'b1;
         req_set   = SET_W'(s ^ 1);
         tick();
         check("stall_resp_valid", resp_valid, 1);
         check("stall_resp_way", resp_way, exp_w);
         check("stall_req_ready", req_ready, 0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("fill_resp_valid", resp_valid, 0);
      check("fill_req_ready", req_ready, 0);
      fill_done = 1'b1;
      inv_all   = fall;
      inv_valid = finv;
      inv_set   = SET_W'(fis);
      inv_way   = WAY_W'(fiw);
      tick();
      fill_done = 1'b0;
      inv_all   = 1'b0;
      inv_valid = 1'b0;
      if (fall) model_clear();
      else begin
         if (finv) mv[fis][fiw] = 1'b0;
         mv[s][exp_w] = 1'b1;
      end
      check("req_ready_after_fill", req_ready, 1);
   endtask

   typedef struct {
      int s;
      int l;
      int stall;
      bit pre_inv;
      int pre_way;
      bit fall;
      int exp_way;
      bit exp_upd;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int w;
      bit u;
      vecs[0] = '{5, 8'h00, 0, 0, 0, 0, 0, 0};
      vecs[1] = '{5, 8'h00, 0, 0, 0, 0, 1, 0};
      vecs[2] = '{5, 8'h00, 0, 0, 0, 0, 2, 0};
      vecs[3] = '{5, 8'h00, 0, 0, 0, 0, 3, 0};
      vecs[4] = '{5, 8'hE6, 0, 0, 0, 0, 2, 1};
      vecs[5] = '{5, 8'hFF, 0, 0, 0, 0, 3, 1};
      vecs[6] = '{5, 8'h00, 0, 1, 1, 0, 1, 0};
      vecs[7] = '{5, 8'h01, 10, 0, 0, 0, 1, 1};
      vecs[8] = '{5, 8'h00, 0, 0, 0, 1, 0, 1};
      vecs[9] = '{5, 8'h00, 0, 0, 0, 0, 0, 0};

      model_clear();
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_lfsr_update", lfsr_update, 0);
      check("rst_resp_way", resp_way, 0);
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].pre_inv) begin
            inv_valid = 1'b1;
            inv_set   = SET_W'(vecs[i].s);
            inv_way   = WAY_W'(vecs[i].pre_way);
            tick();
            inv_valid = 1'b0;
            mv[vecs[i].s][vecs[i].pre_way] = 1'b0;
         end
         do_req(vecs[i].s, vecs[i].l, vecs[i].stall, vecs[i].exp_way, vecs[i].exp_upd,
                0, 0, 0, 0, 0, 0, vecs[i].fall);
      end

      // Reset asserted during RESP aborts without a clock edge and empties the bitmap.
      do_req(5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      req_valid = 1'b1;
      req_set   = SET_W'(5);
      tick();
      req_valid = 1'b0;
      tick();
      check("pre_rst_resp_valid", resp_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_resp_valid", resp_valid, 0);
      check("async_rst_req_ready", req_ready, 1);
      tick();
      rst = 1'b0;
      model_clear();
      tick();
      do_req(5, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int n = 0; n < 200; n++) begin
         int r;
         r = int'($urandom_range(0, 11));
         if (r == 0) begin
            inv_all = 1'b1;
            tick();
            inv_all = 1'b0;
            model_clear();
         end else if (r == 1) begin
            int rs, rw;
            rs = int'($urandom_range(0, 1));
            rw = int'($urandom_range(0, WAYS - 1));
            inv_valid = 1'b1;
            inv_set   = SET_W'(rs);
            inv_way   = WAY_W'(rw);
            tick();
            inv_valid = 1'b0;
            mv[rs][rw] = 1'b0;
         end else if (r == 2) begin
            fill_done = 1'b1;
            tick();
            fill_done = 1'b0;
         end else begin
            int s, l;
            s = int'($urandom_range(0, 1));
            l = int'($urandom_range(0, 255));
            model_pick(s, l, w, u);
            do_req(s, l, int'($urandom_range(0, 2)), w, u,
                   ($urandom_range(0, 3) == 0), s, int'($urandom_range(0, WAYS - 1)),
                   ($urandom_range(0, 2) == 0), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, WAYS - 1)), ($urandom_range(0, 15) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_victim_select.md
# cache_victim_select

Victim-way selector for the set-associative I/D caches and the TLB refill path. Accepts a refill request for a set and returns the way to replace: the lowest-indexed invalid way if one exists, otherwise a pseudo-random way taken from the 8-bit LFSR output. It keeps its own per-set valid bitmap, updated on fill completion and invalidation. It is the consumer of the 8-bit LFSR and drives that LFSR's `update` strobe.

## Interface
Parameters:
- `WAYS`, default 4: associativity. Must be a power of 2 in the range 2..8.
- `SETS`, default 64: number of sets. Must be a power of 2 and at least 2.
- `WAY_W`, default $clog2(WAYS): derived; do not override.
- `SET_W`, default $clog2(SETS): derived; do not override.

Ports:
- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `lfsr_val`, in, 8: current LFSR value.
- `lfsr_update`, out, 1: one-cycle strobe that advances the LFSR.
- `req_valid`, in, 1: victim request.
- `req_set`, in, SET_W: set index of the request.
- `req_ready`, out, 1: high only in IDLE.
- `resp_valid`, out, 1: victim way available.
- `resp_way`, out, WAY_W: selected victim way.
- `resp_ready`, in, 1: consumer accepts the victim.
- `fill_done`, in, 1: one-cycle pulse; the refill of the accepted way is complete.
- `inv_valid`, in, 1: invalidate a single way.
- `inv_set`, in, SET_W: set of the single-way invalidate.
- `inv_way`, in, WAY_W: way of the single-way invalidate.
- `inv_all`, in, 1: clear every valid bit.

## Operation
- State: `valid[SETS][WAYS]`; FSM with states IDLE, PICK, RESP, FILL; registers `set_q` and `way_q`.
- IDLE: `req_ready=1`. When `req_valid` is high, latch `req_set` into `set_q` and go to PICK.
- PICK (exactly one cycle):
  - If any bit of `valid[set_q]` is 0, `way_q` = lowest index with valid 0, and `lfsr_update` stays 0.
  - Otherwise `way_q` = `lfsr_val[WAY_W-1:0]` and `lfsr_update=1` for this cycle.
  - Go to RESP.
- RESP: `resp_valid=1` and `resp_way=way_q`, both held stable until `resp_ready` is high. On `resp_ready`, go to FILL.
- FILL: wait for `fill_done`. On `fill_done`, set `valid[set_q][way_q]=1` and go to IDLE.
- `fill_done` outside FILL is ignored.
- `inv_valid` clears `valid[inv_set][inv_way]` in any state.
- `inv_all` clears all valid bits in any state. It does not change the FSM state.
- Priority when events hit the same bit in the same cycle: `inv_all` > `fill_done` set > `inv_valid` clear.
- An invalidate during PICK updates the bitmap at the same edge. PICK uses the pre-edge bitmap.
- An invalidate of the way currently held in RESP/FILL does not alter `way_q`. The later `fill_done` still sets that bit.
- `resp_way` is driven from `way_q` in all states. It is meaningful only while `resp_valid` is high.

## Timing
- Reset values (asynchronous): FSM=IDLE, `valid`=all 0, `set_q=0`, `way_q=0`, `req_ready=1`, `resp_valid=0`, `lfsr_update=0`.
- Reset asserted mid-operation aborts immediately to the reset values. A pending `fill_done` is lost.
- Request accepted at edge N: PICK during cycle N+1, `resp_valid` high in cycle N+2 (2-cycle latency).
- `lfsr_update` is high only in the PICK cycle. `lfsr_val` is sampled in that same cycle, so the advanced LFSR value is used by the next miss.
- Back-to-back throughput: minimum 4 cycles per request (IDLE, PICK, RESP, FILL), plus consumer stalls.
- `req_ready`, `resp_valid` and `lfsr_update` are decoded from registered state only. There is no combinational path from any input to these outputs.

## Test plan
- Reset, WAYS=4: request set 5 four times, with `fill_done` after each → `resp_way` = 0, 1, 2, 3 in order. `lfsr_update` never asserted. `resp_valid` high 2 cycles after each accept.
- Set 5 full, `lfsr_val=8'hE6` → `resp_way=2`, with `lfsr_update` high for exactly 1 cycle in PICK. Repeat with `8'hFF` → `resp_way=3`.
- Set 5 full, `inv_valid` on set 5 way 1, then a request → `resp_way=1` and `lfsr_update=0`.
- Stall: hold `resp_ready=0` for 10 cycles → `resp_valid` and `resp_way` stay stable, `req_ready=0`, and a new `req_valid` is not accepted.
- In FILL, assert `fill_done` and `inv_all` in the same cycle → all valid bits 0 and FSM in IDLE. The next request returns way 0.
- Assert `rst` during RESP → `resp_valid` drops without waiting for a clock edge, and `req_ready=1`. The next request to the previously filled set returns way 0.
